// File: rtl/text_pkg.sv
// Shared constants, pipeline payload types and sizing helper for the text overlay.
package text_pkg;

    localparam logic [6:0] CH_SPACE = 7'h20;
    localparam logic [6:0] CH_0     = 7'h30;
    localparam logic [6:0] CH_COLON = 7'h3A;
    localparam logic [6:0] CH_A     = 7'h41;
    localparam logic [6:0] CH_E     = 7'h45;
    localparam logic [6:0] CH_G     = 7'h47;
    localparam logic [6:0] CH_N     = 7'h4E;
    localparam logic [6:0] CH_O     = 7'h4F;
    localparam logic [6:0] CH_P     = 7'h50;
    localparam logic [6:0] CH_S     = 7'h53;
    localparam logic [6:0] CH_W     = 7'h57;

    localparam logic [11:0] RGB_BLACK = 12'h000;
    localparam logic [11:0] RGB_WHITE = 12'hFFF;
    localparam logic [11:0] RGB_RED   = 12'hF00;
    localparam logic [11:0] RGB_CYAN  = 12'h0FF;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic       hit;
        logic       blink;
        logic [2:0] bit_idx;
        logic [3:0] line;
    } s1_t;

    typedef struct packed {
        logic       hit;
        logic       blank;
        logic [2:0] bit_idx;
    } s2_t;

    // Character-buffer address width; never below one bit.
    function automatic int unsigned calc_aw(input int unsigned cols, input int unsigned rows);
        return (cols * rows > 1) ? $clog2(cols * rows) : 1;
    endfunction

endpackage

// File: rtl/ascii_rom.sv
// 8x16 glyph ROM addressed by {code[6:0], line[3:0]}, one-cycle registered read.
module ascii_rom (
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    localparam logic [127:0] G_0     = 128'h00007CC6CEDEF6E6C6C6C67C00000000;
    localparam logic [127:0] G_COLON = 128'h00000000181800000018180000000000;
    localparam logic [127:0] G_A     = 128'h000010386CC6C6FEC6C6C6C600000000;
    localparam logic [127:0] G_P     = 128'h0000FC6666667C60606060F000000000;
    localparam logic [127:0] G_S     = 128'h00007CC6C660380C06C6C67C00000000;

    logic [127:0] glyph_c;
    logic [7:0]   row_c;

    always_comb begin
        glyph_c = '0;
        case (addr[10:4])
            7'h30:   glyph_c = G_0;
            7'h3A:   glyph_c = G_COLON;
            7'h41:   glyph_c = G_A;
            7'h50:   glyph_c = G_P;
            7'h53:   glyph_c = G_S;
            default: glyph_c = '0;
        endcase
        // Line 0 is the top row, stored in the most significant byte.
        row_c = 8'(glyph_c >> (8 * (15 - 32'(addr[3:0]))));
    end

    always_ff @(posedge clk) begin
        data <= row_c;
    end

endmodule

// File: rtl/text_char_ram.sv
// Character buffer: one synchronous write port, one registered read port, read-before-write.
module text_char_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q;

    // Non-blocking read of mem returns the pre-write contents on a same-index collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/text_layer_engine.sv
// Text overlay: character-buffer clear FSM, frame blink timer and 3-stage glyph render pipeline.
module text_layer_engine
    import text_pkg::*;
#(
    parameter int unsigned COLS         = 16,
    parameter int unsigned ROWS         = 4,
    parameter int unsigned SCALE_LOG2   = 1,
    parameter int unsigned X0           = 0,
    parameter int unsigned Y0           = 32,
    parameter logic [11:0] FG_RGB       = RGB_RED,
    parameter logic [11:0] BG_RGB       = RGB_CYAN,
    parameter int unsigned BLINK_FRAMES = 30,
    localparam int unsigned AW          = calc_aw(COLS, ROWS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          frame_tick,
    input  logic          clr_req,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    output logic          text_on,
    output logic [11:0]   text_rgb
);

    localparam int unsigned DEPTH = COLS * ROWS;
    localparam int unsigned CBW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned CW    = 16;
    localparam int unsigned REG_W = (COLS * 8) << SCALE_LOG2;
    localparam int unsigned REG_H = (ROWS * 16) << SCALE_LOG2;
    localparam int unsigned BCW   = $clog2(BLINK_FRAMES + 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            wr_ready_q, wr_ready_d;
    logic            armed_q, armed_d;
    logic [BCW-1:0]  bcnt_q, bcnt_d;
    logic            bph_q, bph_d;
    s1_t             s1_q, s1_d;
    s2_t             s2_q, s2_d;
    logic            text_on_q, text_on_d;
    logic [11:0]     text_rgb_q, text_rgb_d;

    logic            ram_we_c;
    logic [AW-1:0]   ram_wa_c;
    logic [7:0]      ram_wd_c;
    logic [CW-1:0]   dx_c, dy_c;
    logic            hit_c;
    logic [AW-1:0]   rd_idx_c;
    logic [7:0]      ram_rd_data;
    logic [10:0]     rom_addr_c;
    logic [7:0]      rom_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_CLEAR;
            idx_q      <= '0;
            wr_ready_q <= 1'b0;
            armed_q    <= 1'b0;
            bcnt_q     <= '0;
            bph_q      <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            text_on_q  <= 1'b0;
            text_rgb_q <= BG_RGB;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_ready_q <= wr_ready_d;
            armed_q    <= armed_d;
            bcnt_q     <= bcnt_d;
            bph_q      <= bph_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            text_on_q  <= text_on_d;
            text_rgb_q <= text_rgb_d;
        end
    end

    // Clear sweep owns the write port in CLEAR; host writes pass through in RUN.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ram_we_c = 1'b0;
        ram_wa_c = wr_addr;
        ram_wd_c = wr_data;
        case (state_q)
            ST_CLEAR: begin
                ram_we_c = 1'b1;
                ram_wa_c = idx_q;
                ram_wd_c = 8'h00;
                if (clr_req) begin
                    idx_d = '0;
                end else if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            ST_RUN: begin
                ram_we_c = wr_en && wr_ready_q;
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
        wr_ready_d = (state_d == ST_RUN);
    end

    // armed_q masks a frame_tick landing on the first edge after reset release.
    always_comb begin
        armed_d = 1'b1;
        bcnt_d  = bcnt_q;
        bph_d   = bph_q;
        if (frame_tick && armed_q) begin
            if (bcnt_q == BCW'(BLINK_FRAMES - 1)) begin
                bcnt_d = '0;
                bph_d  = ~bph_q;
            end else begin
                bcnt_d = bcnt_q + BCW'(1);
            end
        end
    end

    // S0: x < X0 or y < Y0 wraps dx/dy far beyond the region, so range checks cover it.
    always_comb begin
        dx_c        = CW'(x) - CW'(X0);
        dy_c        = CW'(y) - CW'(Y0);
        hit_c       = (dx_c < CW'(REG_W)) && (dy_c < CW'(REG_H));
        rd_idx_c    = AW'((32'(dy_c >> (4 + SCALE_LOG2)) << CBW) | 32'(dx_c >> (3 + SCALE_LOG2)));
        s1_d        = '0;
        s1_d.hit    = hit_c && (state_q == ST_RUN);
        s1_d.blink  = bph_q;
        s1_d.bit_idx = 3'(dx_c >> SCALE_LOG2);
        s1_d.line   = 4'(dy_c >> SCALE_LOG2);
    end

    // S1: character from buffer forms the ROM address; blink mask resolved here.
    always_comb begin
        rom_addr_c   = {ram_rd_data[6:0], s1_q.line};
        s2_d         = '0;
        s2_d.hit     = s1_q.hit;
        s2_d.blank   = ram_rd_data[7] && s1_q.blink;
        s2_d.bit_idx = s1_q.bit_idx;
    end

    // S2: leftmost pixel is ROM bit 7, so bit (7 - bit_idx) == ~bit_idx.
    always_comb begin
        text_on_d  = s2_q.hit && rom_data[~s2_q.bit_idx] && !s2_q.blank;
        text_rgb_d = text_on_d ? FG_RGB : BG_RGB;
    end

    text_char_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_char_ram (
        .clk     (clk),
        .wr_en   (ram_we_c),
        .wr_addr (ram_wa_c),
        .wr_data (ram_wd_c),
        .rd_addr (rd_idx_c),
        .rd_data (ram_rd_data)
    );

    ascii_rom u_ascii_rom (
        .clk  (clk),
        .addr (rom_addr_c),
        .data (rom_data)
    );

    assign wr_ready = wr_ready_q;
    assign text_on  = text_on_q;
    assign text_rgb = text_rgb_q;

endmodule

// File: tb/tb_text_layer_engine.sv
// Directed bench for text_layer_engine with default parameters (16x4 grid, 2x scale, origin 0,32).
module tb_text_layer_engine;

    localparam logic [11:0] FG = 12'hF00;
    localparam logic [11:0] BG = 12'h0FF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  x, y;
    logic        frame_tick, clr_req, wr_en;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready, text_on;
    logic [11:0] text_rgb;

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] shadow [64];
    logic       bph;
    int         fcnt;
    logic       in_clear;

    logic [7:0] gl_s [16] = '{8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'h60, 8'h38, 8'h0C,
                              8'h06, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] gl_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                              8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

    text_layer_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .clr_req    (clr_req),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .text_on    (text_on),
        .text_rgb   (text_rgb)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish, expected finish before 5ms");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [6:0] c, input int l);
        if (c == 7'h53) return gl_s[l];
        if (c == 7'h41) return gl_a[l];
        return 8'h00;
    endfunction

    // Reference pixel model using division on plain integers.
    function automatic logic exp_on(input int xi, input int yi);
        int dx, dy, idx, b;
        logic [7:0] ch, g;
        if (in_clear) return 1'b0;
        if (xi < 0 || yi < 32) return 1'b0;
        dx = xi;
        dy = yi - 32;
        if (dx >= 256 || dy >= 128) return 1'b0;
        idx = (dy / 32) * 16 + dx / 16;
        ch  = shadow[idx];
        g   = glyph(ch[6:0], (dy / 2) % 16);
        b   = (dx / 2) % 8;
        return g[7 - b] && !(ch[7] && bph);
    endfunction

    function automatic logic [12:0] exp_px(input int xi, input int yi);
        logic e;
        e = exp_on(xi, yi);
        return {e, e ? FG : BG};
    endfunction

    task automatic probe(input int xi, input int yi, input string tag);
        x = 10'(xi);
        y = 10'(yi);
        repeat (3) tick();
        check(32'({text_on, text_rgb}), 32'(exp_px(xi, yi)), $sformatf("%s(%0d,%0d)", tag, xi, yi));
    endtask

    // One pixel per clock; each result is checked exactly three edges after its sample.
    task automatic sweep(input int x_lo, input int nx, input int y_lo, input int ny, input int ystep,
                         input string tag);
        int n, j, xj, yj;
        n = nx * ny;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                x = 10'(x_lo + i % nx);
                y = 10'(y_lo + (i / nx) * ystep);
            end
            tick();
            if (i >= 2) begin
                j  = i - 2;
                xj = x_lo + j % nx;
                yj = y_lo + (j / nx) * ystep;
                check(32'({text_on, text_rgb}), 32'(exp_px(xj, yj)), $sformatf("%s(%0d,%0d)", tag, xj, yj));
            end
        end
    endtask

    task automatic write_char(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 6'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        shadow[a] = d;
    endtask

    task automatic pulse_frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        fcnt++;
        if (fcnt == 30) begin
            fcnt = 0;
            bph  = ~bph;
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!wr_ready && n < 200) begin
            tick();
            n++;
        end
        check(32'(n), 32'd64, tag);
    endtask

    initial begin
        reset_n    = 1'b0;
        x          = '0;
        y          = '0;
        frame_tick = 1'b0;
        clr_req    = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        bph        = 1'b0;
        fcnt       = 0;
        in_clear   = 1'b1;
        for (int i = 0; i < 64; i++) shadow[i] = 8'h00;

        repeat (3) tick();
        check(32'(wr_ready), 32'd0, "rst_wr_ready");
        check(32'(text_on), 32'd0, "rst_text_on");
        check(32'(text_rgb), 32'(BG), "rst_text_rgb");

        // Reset release: sweep of 64 cycles, pixels forced off meanwhile.
        x = 10'd4;
        y = 10'd36;
        reset_n = 1'b1;
        wait_ready("clear_len_after_reset");
        check(32'(text_on), 32'd0, "clear_text_on");
        in_clear = 1'b0;

        sweep(0, 256, 32, 64, 2, "blank_region");

        // 'S' at index 0 at 2x scale, full glyph cell.
        write_char(0, 8'h53);
        sweep(0, 16, 32, 32, 1, "glyph_S");

        // Blinking 'A' at index 1.
        write_char(1, 8'hC1);
        probe(22, 36, "blink_f0");
        repeat (29) pulse_frame();
        probe(22, 36, "blink_f29");
        pulse_frame();
        probe(22, 36, "blink_f30");
        probe(4, 36, "noblink_S_f30");
        repeat (29) pulse_frame();
        probe(22, 36, "blink_f59");
        // Toggle edge samples the old phase; the next pixel sees the new phase.
        x = 10'd22;
        y = 10'd36;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
        check(32'(text_on), 32'd0, "blink_toggle_edge_old");
        tick();
        check(32'(text_on), 32'd1, "blink_toggle_edge_new");
        bph  = 1'b0;
        fcnt = 0;

        // Same-cycle write and render read of index 2: old (blank) then new ('S').
        x       = 10'd36;
        y       = 10'd36;
        wr_en   = 1'b1;
        wr_addr = 6'd2;
        wr_data = 8'h53;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        check(32'(text_on), 32'd0, "rw_collision_old");
        tick();
        check(32'(text_on), 32'd1, "rw_collision_new");
        shadow[2] = 8'h53;

        // clr_req in RUN; writes attempted during the sweep must be dropped.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check(32'(wr_ready), 32'd0, "clr_ready_low");
        wr_en   = 1'b1;
        wr_addr = 6'd5;
        wr_data = 8'h53;
        wait_ready("clear_len_after_clr_req");
        wr_en = 1'b0;
        for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
        sweep(0, 256, 32, 64, 2, "after_clear");

        // Boundary pixels, with lit glyphs placed where an off-by-one would land.
        write_char(0, 8'h53);
        write_char(63, 8'h53);
        probe(0, 38, "bound_ctrl_lit");
        probe(1023, 38, "bound_x0m1");
        probe(6, 31, "bound_y0m1");
        probe(256, 38, "bound_x0p256");
        probe(0, 166, "bound_y0p128");
        probe(255, 159, "bound_last_px");

        // Asynchronous reset mid-frame while a lit pixel is showing.
        probe(0, 38, "pre_reset_lit");
        reset_n = 1'b0;
        #2;
        check(32'({wr_ready, text_on, text_rgb}), 32'({1'b0, 1'b0, BG}), "async_reset_outputs");
        tick();
        reset_n  = 1'b1;
        in_clear = 1'b1;
        wait_ready("clear_len_after_midreset");
        in_clear = 1'b0;
        for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
        probe(0, 38, "post_reset_cleared");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/text_layer_engine.md
# text_layer_engine

Parametrised text-overlay generator for the VGA pong pipeline: renders a COLS×ROWS grid of 8×16 ASCII glyphs, scaled by 2^SCALE_LOG2, at a configurable screen origin. Glyph codes live in a writable character buffer rather than hard-wired case tables. Per-character blink and a post-reset buffer-clear sequencer are built in. It sits beside the pixel generator and feeds its RGB mux with a fixed, documented pixel latency.

## Interface
- COLS, 16, characters per row; power of 2, 2..64
- ROWS, 4, character rows; power of 2, 1..16
- SCALE_LOG2, 1, glyph scale exponent, 0..3 (1 = 16×32 px per glyph)
- X0, 0, region left edge in pixels
- Y0, 32, region top edge in pixels
- FG_RGB, 12'hF00, glyph foreground colour
- BG_RGB, 12'h0FF, colour driven when no glyph pixel is lit
- BLINK_FRAMES, 30, frames per blink half-period, ≥1
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- x, y  in  10 each  current pixel coordinate from vga_controller
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- clr_req  in  1  pulse: re-run buffer clear
- wr_en  in  1  character write strobe
- wr_addr  in  AW = log2(COLS·ROWS)  buffer index {row, col}
- wr_data  in  8  [7] blink attribute, [6:0] ASCII code
- wr_ready  out  1  high when writes are accepted
- text_on  out  1  pixel is inside the region and the glyph bit is lit
- text_rgb  out  12  FG_RGB when text_on, else BG_RGB

## Operation
- Region hit: dx = x−X0 and dy = y−Y0, both unsigned, with 0 ≤ dx < COLS·8·2^S and 0 ≤ dy < ROWS·16·2^S. If x < X0 or y < Y0, there is no hit.
- Address derivation:
  - col = dx >> (3+S)
  - bit = (dx >> S) & 7
  - row = dy >> (4+S)
  - line = (dy >> S) & 15
  - Buffer index = {row, col}.
- Pixel lit when glyph ROM bit (7−bit) of word {char[6:0], line} is 1, and not (char[7] && blink_phase).
- Writes: accepted on a clk edge with wr_en && wr_ready. When wr_ready is low, the write is silently dropped; no queueing.
- Read/write to the same index in the same cycle: the render read returns the old data.
- Blink: a counter increments on frame_tick. When it reaches BLINK_FRAMES−1, it clears and blink_phase toggles.
- FSM, two states:
  - CLEAR: writes 8'h00 to index 0..COLS·ROWS−1, one per cycle. wr_ready = 0. text_on is forced 0. Moves to RUN after the last index.
  - RUN: wr_ready = 1. A clr_req pulse moves to CLEAR starting at index 0.
- clr_req received while already in CLEAR restarts the sweep at index 0.

## Timing
- Reset state (asynchronous):
  - FSM in CLEAR, sweep index 0, wr_ready 0
  - text_on 0, text_rgb BG_RGB
  - blink counter 0, blink_phase 0
- Clear sweep takes COLS·ROWS cycles after reset release; wr_ready rises on the following cycle.
- Render latency is exactly 3 clk from (x,y) to text_on/text_rgb:
  - S0: region and index compute, buffer read issued
  - S1: ROM address formed, ROM read
  - S2: bit select, registered outputs
- The hit flag and bit index are pipelined alongside the data.
- A pipeline bubble from CLEAR forces text_on 0 for pixels sampled while in CLEAR.
- Write visibility: a character written at edge N renders for pixels sampled at edge N+1 onward.
- frame_tick coinciding with reset deassertion is ignored.
- The blink_phase change applies to pixels sampled after the toggling edge.
- Reset asserted mid-sweep or mid-frame: all state returns to reset values immediately; the sweep restarts from 0.

## Structure
- Shared package text_pkg:
  - ASCII constants (CH_SPACE, CH_0, CH_COLON, letters used by the game)
  - RGB colour constants
  - AW helper function
- Existing ascii_rom is instantiated unchanged (1-cycle registered read).
- Sub-module text_char_ram: COLS·ROWS×8 simple dual-port RAM, one synchronous write port, one registered read port, read-before-write. No reset on the array.
- Top level holds the FSM, the blink counter and the 3-stage render pipeline.

## Test plan
- Reset release with defaults: wr_ready low for 64 cycles then high; sweeping every pixel of the region gives text_on = 0 everywhere.
- Write 8'h53 ('S') at index 0, then sample x = 0..15, y = 32..63: text_on matches the 'S' glyph at 2× scale, delayed exactly 3 clk; text_rgb = 12'hF00 on lit pixels, 12'h0FF elsewhere.
- Write 8'hC1 (blinking 'A'), then pulse frame_tick 30 times: glyph lit for frames 0–29, blank for frames 30–59, lit again from frame 60.
- wr_en with the same index in the same cycle as the render read of that index: the old glyph renders on that pixel, the new glyph on the next access.
- clr_req in RUN with the buffer populated: wr_ready low for 64 cycles, writes during that window are dropped, and the buffer reads all zeros afterward.
- Boundary coordinates x = X0−1, y = Y0−1, x = X0+256, y = Y0+128: text_on 0 at each.
